// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - 4x4 card-matching game controller with cursor, pick FSM and mismatch hold timer
module memory_game_ctrl #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    output logic [15:0] face_up,
    output logic [3:0]  cursor,
    output logic [3:0]  pairs_found,
    output logic [7:0]  moves,
    output logic        won
);

    // Hold timer only needs to count HOLD_CYCLES-1 down to 0.
    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        PICK1   = 3'd0,
        PICK2   = 3'd1,
        COMPARE = 3'd2,
        SHOW    = 3'd3,
        WON     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   matched_q, matched_d;
    logic [15:0]   revealed_q, revealed_d;
    logic [15:0]   face_q, face_d;
    logic [3:0]    first_q, first_d;
    logic [3:0]    second_q, second_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    cursor_q, cursor_d;
    logic [3:0]    pairs_q, pairs_d;
    logic [7:0]    moves_q, moves_d;
    logic          won_q, won_d;

    logic          sel_ok;
    logic [1:0]    row, col;

    assign face_up     = face_q;
    assign cursor      = cursor_q;
    assign pairs_found = pairs_q;
    assign moves       = moves_q;
    assign won         = won_q;

    assign row    = cursor_q[3:2];
    assign col    = cursor_q[1:0];
    // A pick only qualifies on a card that is currently face down; selects
    // always look at the pre-move cursor.
    assign sel_ok = btn_sel && !face_q[cursor_q];

    // Next-state logic: cursor movement, pick sequencing, compare and hold.
    always_comb begin
        state_d    = state_q;
        matched_d  = matched_q;
        revealed_d = revealed_q;
        first_d    = first_q;
        second_d   = second_q;
        timer_d    = timer_q;
        cursor_d   = cursor_q;
        pairs_d    = pairs_q;
        moves_d    = moves_q;

        // Row/column are 2-bit fields, so +/-1 wraps 0<->3 naturally.
        if (state_q != WON) begin
            if (btn_up)         cursor_d = {row - 2'd1, col};
            else if (btn_down)  cursor_d = {row + 2'd1, col};
            else if (btn_left)  cursor_d = {row, col - 2'd1};
            else if (btn_right) cursor_d = {row, col + 2'd1};
        end

        case (state_q)
            PICK1: begin
                if (sel_ok) begin
                    first_d              = cursor_q;
                    revealed_d[cursor_q] = 1'b1;
                    state_d              = PICK2;
                end
            end
            PICK2: begin
                // The first pick is already face up, so it cannot be re-picked.
                if (sel_ok) begin
                    second_d             = cursor_q;
                    revealed_d[cursor_q] = 1'b1;
                    if (moves_q != 8'hFF) moves_d = moves_q + 8'd1;
                    state_d              = COMPARE;
                end
            end
            COMPARE: begin
                // Cards i and i^8 pair up, so only the low three bits matter.
                if (first_q[2:0] == second_q[2:0]) begin
                    matched_d[first_q]  = 1'b1;
                    matched_d[second_q] = 1'b1;
                    revealed_d          = 16'h0000;
                    pairs_d             = pairs_q + 4'd1;
                    state_d             = (pairs_q == 4'd7) ? WON : PICK1;
                end else begin
                    timer_d = HOLD_LOAD;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (timer_q == '0) begin
                    revealed_d = 16'h0000;
                    state_d    = PICK1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            WON: begin
                if (btn_sel) begin
                    matched_d  = 16'h0000;
                    revealed_d = 16'h0000;
                    first_d    = 4'd0;
                    second_d   = 4'd0;
                    timer_d    = '0;
                    cursor_d   = 4'd0;
                    pairs_d    = 4'd0;
                    moves_d    = 8'd0;
                    state_d    = PICK1;
                end
            end
            default: state_d = PICK1;
        endcase

        // Outputs are registered from next-state values so a pick shows one
        // cycle after its select.
        face_d = (state_d == WON) ? 16'hFFFF : (matched_d | revealed_d);
        won_d  = (state_d == WON);
    end

    // State and output registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PICK1;
            matched_q  <= 16'h0000;
            revealed_q <= 16'h0000;
            face_q     <= 16'h0000;
            first_q    <= 4'd0;
            second_q   <= 4'd0;
            timer_q    <= '0;
            cursor_q   <= 4'd0;
            pairs_q    <= 4'd0;
            moves_q    <= 8'd0;
            won_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            matched_q  <= matched_d;
            revealed_q <= revealed_d;
            face_q     <= face_d;
            first_q    <= first_d;
            second_q   <= second_d;
            timer_q    <= timer_d;
            cursor_q   <= cursor_d;
            pairs_q    <= pairs_d;
            moves_q    <= moves_d;
            won_q      <= won_d;
        end
    end

endmodule
